// File: rtl/da_dct_pkg.sv
// -----------------------------------------------------------------------------
// da_dct_pkg
// Shared constants and state type for the distributed-arithmetic DCT
// controller.
//   DW      : sample width, which is also the number of bit-plane iterations
//   RW      : ROM coefficient width (signed fixed point)
//   AW      : accumulator and result width
//   state_e : controller states IDLE / RUN / HOLD
// -----------------------------------------------------------------------------
package da_dct_pkg;

  localparam int DW = 16;
  localparam int RW = 16;
  // Two guard bits above DW+RW keep the shift-accumulate free of overflow.
  localparam int AW = DW + RW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/da_accum.sv
// -----------------------------------------------------------------------------
// da_accum
// Shift-accumulate datapath for one distributed-arithmetic sum. When enabled,
// each cycle computes acc = (acc << 1) +/- sext(rom_data).
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : zero the accumulator; wins over enable
//   enable     : perform one shift-accumulate step
//   subtract   : subtract the coefficient instead of adding it (sign plane)
//   rom_data   : signed coefficient from the ROM
//   acc        : signed accumulator value
// -----------------------------------------------------------------------------
module da_accum #(
  parameter int RW = da_dct_pkg::RW,
  parameter int AW = da_dct_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 subtract,
  input  logic        [RW-1:0] rom_data,
  output logic signed [AW-1:0] acc
);

  logic signed [AW-1:0] coef_ext;

  assign coef_ext = {{(AW-RW){rom_data[RW-1]}}, rom_data};

  // NOTE: reset is sampled on the clock edge (synchronous), so it is not in
  // the sensitivity list; sequential state is written only with <=.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= subtract ? (acc <<< 1) - coef_ext : (acc <<< 1) + coef_ext;
    end
  end

endmodule

// File: rtl/da_dct_ctrl.sv
// -----------------------------------------------------------------------------
// da_dct_ctrl
// Distributed-arithmetic controller: accepts three signed samples, walks
// their bit planes MSB first, addresses a coefficient ROM with one bit of
// each sample per cycle and accumulates the ROM output into a signed result.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   clr                 : synchronous abort back to IDLE, result dropped
//   in_valid, in_ready  : sample-set handshake
//   x1, x2, x3          : signed samples
//   rom_cs, rom_addr    : ROM chip select and address {x1[b],x2[b],x3[b]}
//   rom_data            : signed ROM coefficient (combinational from rom_addr)
//   out_valid, out_ready: result handshake
//   out_data            : signed result
//   busy                : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module da_dct_ctrl #(
  parameter int DW = da_dct_pkg::DW,
  parameter int RW = da_dct_pkg::RW,
  parameter int AW = da_dct_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic        [DW-1:0] x1,
  input  logic        [DW-1:0] x2,
  input  logic        [DW-1:0] x3,
  output logic                 rom_cs,
  output logic        [2:0]    rom_addr,
  input  logic        [RW-1:0] rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_data,
  output logic                 busy
);

  import da_dct_pkg::state_e;
  import da_dct_pkg::IDLE;
  import da_dct_pkg::RUN;
  import da_dct_pkg::HOLD;

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  state_e               state;
  logic [BW-1:0]        b;
  logic [DW-1:0]        x1_s;
  logic [DW-1:0]        x2_s;
  logic [DW-1:0]        x3_s;
  logic                 ready_en;
  logic                 accept;
  logic                 in_run;
  logic                 sign_plane;
  logic signed [AW-1:0] acc;

  // ready_en stays low for the first cycle after reset release so nothing is
  // accepted while the ROM output is still gated.
  assign in_ready   = (state == IDLE) && ready_en && !clr;
  assign accept     = in_valid && in_ready;
  assign in_run     = (state == RUN);
  assign sign_plane = (b == BW'(DW - 1));

  assign rom_cs   = in_run;
  assign rom_addr = in_run ? {x1_s[b], x2_s[b], x3_s[b]} : 3'd0;

  // clr suppresses out_valid in its own cycle so an abort can never complete
  // a result handshake.
  assign out_valid = (state == HOLD) && !clr;
  assign out_data  = acc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      b        <= '0;
      x1_s     <= '0;
      x2_s     <= '0;
      x3_s     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (clr) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              x1_s  <= x1;
              x2_s  <= x2;
              x3_s  <= x3;
              b     <= BW'(DW - 1);
              state <= RUN;
            end
          end
          RUN: begin
            if (b == '0) begin
              state <= HOLD;
            end else begin
              b <= b - 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  da_accum #(
    .RW (RW),
    .AW (AW)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clr || accept),
    .enable   (in_run),
    .subtract (sign_plane),
    .rom_data (rom_data),
    .acc      (acc)
  );

endmodule
